// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one external BITxBIT multiplier between two requesters.
// Operands are latched into registers that drive the multiplier; the product returns via valid/ready.
module mult_rr_scheduler #(
  parameter int BIT   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [BIT-1:0]   req_a0,
  input  logic [BIT-1:0]   req_b0,
  input  logic [BIT-1:0]   req_a1,
  input  logic [BIT-1:0]   req_b1,
  output logic [BIT-1:0]   mul_a,
  output logic [BIT-1:0]   mul_b,
  input  logic [2*BIT-1:0] mul_p,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [2*BIT-1:0] resp_result,
  output logic             resp_oflow,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t state;
  logic   rr_last;
  logic   cur_id;
  logic   any_valid;
  logic   grant;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    any_valid = |req_valid;
    grant     = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready = {grant, ~grant};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      cur_id      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_oflow  <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            mul_a   <= grant ? req_a1 : req_a0;
            mul_b   <= grant ? req_b1 : req_b0;
            cur_id  <= grant;
            rr_last <= grant;
            state   <= CALC;
          end
        end
        CALC: begin
          resp_result <= mul_p;
          resp_oflow  <= |mul_p[2*BIT-1:BIT];
          resp_id     <= cur_id;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: scenario tasks plus a scoreboard monitor.
// A second instance with a 2-bit counter exercises op_count saturation on the same stimulus.
module tb_mult_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic       resp_ready;

  logic [1:0]  req_ready, s_req_ready;
  logic [3:0]  mul_a, mul_b, s_mul_a, s_mul_b;
  logic [7:0]  mul_p, s_mul_p;
  logic        resp_valid, resp_id, resp_oflow, busy;
  logic [7:0]  resp_result;
  logic [15:0] op_count;
  logic        s_resp_valid, s_resp_id, s_resp_oflow, s_busy;
  logic [7:0]  s_resp_result;
  logic [1:0]  s_op_count;

  // Behavioural stand-ins for the external multiplier
  assign mul_p   = {4'b0, mul_a} * {4'b0, mul_b};
  assign s_mul_p = {4'b0, s_mul_a} * {4'b0, s_mul_b};

  always #5 clk = ~clk;

  mult_rr_scheduler #(.BIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_oflow(resp_oflow), .busy(busy), .op_count(op_count)
  );

  mult_rr_scheduler #(.BIT(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
    .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_id(s_resp_id),
    .resp_result(s_resp_result), .resp_oflow(s_resp_oflow), .busy(s_busy), .op_count(s_op_count)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       oflow;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0;
  int   mon_pass = 0, mon_total = 0;

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        exp_t e;
        logic [3:0] a, b;
        e.id     = req_ready[1];
        a        = e.id ? req_a1 : req_a0;
        b        = e.id ? req_b1 : req_b0;
        e.result = {4'b0, a} * {4'b0, b};
        e.oflow  = (e.result > 8'd15);
        sb.push_back(e);
      end
      if (resp_valid && resp_ready) begin
        mon_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected_resp: got id=%0d result=%0d, required no response", resp_id, resp_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({resp_id, resp_result, resp_oflow} !== {e.id, e.result, e.oflow})
            $display("FAIL sb_resp: got id=%0d result=%0d oflow=%0d, required id=%0d result=%0d oflow=%0d",
                     resp_id, resp_result, resp_oflow, e.id, e.result, e.oflow);
          else mon_pass++;
        end
      end
      if (busy) begin
        mon_total++;
        if (req_ready !== 2'b00) $display("FAIL ready_when_busy: got %b, required 00", req_ready);
        else mon_pass++;
      end
    end
  end

  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b, input int exp_cnt);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    @(posedge clk); #1;
    resp_ready = 1'b1;
    if (id) begin req_a1 = a; req_b1 = b; req_valid = 2'b10; end
    else    begin req_a0 = a; req_b0 = b; req_valid = 2'b01; end
    #1;
    n_total++;
    if (req_ready !== (id ? 2'b10 : 2'b01)) $display("FAIL op_ready: got %b, required %b", req_ready, id ? 2'b10 : 2'b01);
    else n_pass++;
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    n_total++;
    if ({busy, resp_valid, mul_a, mul_b} !== {1'b1, 1'b0, a, b})
      $display("FAIL op_calc: got busy=%0d rv=%0d mul_a=%0d mul_b=%0d, required 1 0 %0d %0d", busy, resp_valid, mul_a, mul_b, a, b);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({resp_valid, resp_id, resp_result, resp_oflow} !== {1'b1, id, p, p > 8'd15})
      $display("FAIL op_resp: got rv=%0d id=%0d result=%0d oflow=%0d, required 1 %0d %0d %0d",
               resp_valid, resp_id, resp_result, resp_oflow, id, p, p > 8'd15);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({resp_valid, busy, op_count} !== {1'b0, 1'b0, 16'(exp_cnt)})
      $display("FAIL op_done: got rv=%0d busy=%0d op_count=%0d, required 0 0 %0d", resp_valid, busy, op_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({req_ready, mul_a, mul_b, resp_valid, resp_id, resp_result, resp_oflow, busy, op_count} !== '0)
      $display("FAIL reset_outputs: got nonzero output, busy=%0d rv=%0d op_count=%0d", busy, resp_valid, op_count);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({busy, resp_valid, req_ready} !== 4'b0) $display("FAIL reset_release: got busy=%0d rv=%0d ready=%b, required 0", busy, resp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    do_op(1'b0, 4'd3, 4'd5, 1);
  endtask

  task automatic test_overflow();
    do_op(1'b1, 4'd15, 4'd15, 2);
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_a0 = 4'd9; req_b0 = 4'd2; req_a1 = 4'd1; req_b1 = 4'd1;
    req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b10;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    n_total++;
    if (!seen) $display("FAIL bp_timeout: got no resp_valid, required resp_valid within 10 cycles");
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_total++;
      if ({resp_valid, busy, req_ready, resp_id, resp_result, resp_oflow} !== {1'b1, 1'b1, 2'b00, 1'b0, 8'd18, 1'b1})
        $display("FAIL bp_stall: got rv=%0d busy=%0d ready=%b id=%0d result=%0d oflow=%0d, required 1 1 00 0 18 1",
                 resp_valid, busy, req_ready, resp_id, resp_result, resp_oflow);
      else n_pass++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({busy, req_ready, op_count} !== {1'b0, 2'b00, 16'd3})
        $display("FAIL withdraw_idle: got busy=%0d ready=%b op_count=%0d, required 0 00 3", busy, req_ready, op_count);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_a0 = 4'd6; req_b0 = 4'd7; req_valid = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    n_total++;
    if (!seen) $display("FAIL rst_mid_timeout: got no resp_valid, required resp_valid within 10 cycles");
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready, mul_a, mul_b, resp_valid, resp_id, resp_result, resp_oflow, busy, op_count, s_op_count} !== '0)
      $display("FAIL rst_mid_async: got busy=%0d rv=%0d result=%0d op_count=%0d, required all 0", busy, resp_valid, resp_result, op_count);
    else n_pass++;
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, resp_valid, op_count} !== '0) $display("FAIL rst_mid_idle: got busy=%0d rv=%0d op_count=%0d, required 0", busy, resp_valid, op_count);
    else n_pass++;
  endtask

  task automatic test_tie();
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_a0 = 4'd7; req_b0 = 4'd9; req_a1 = 4'd12; req_b1 = 4'd13;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit seen = 0;
      logic [1:0] exp_rdy;
      exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = (req_ready != 2'b00);
      end
      n_total++;
      if (req_ready !== exp_rdy) $display("FAIL tie_grant%0d: got %b, required %b", k, req_ready, exp_rdy);
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = resp_valid;
      end
      n_total++;
      if (!seen || resp_id !== exp_rdy[1]) $display("FAIL tie_id%0d: got valid=%0d id=%0d, required 1 %0d", k, seen, resp_id, exp_rdy[1]);
      else n_pass++;
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    @(negedge clk) rst_n = 1'b0;
    sb.delete();
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      do_op(k[0], 4'(k + 1), 4'(k + 8), k);
      n_total++;
      if (s_op_count !== 2'((k > 3) ? 3 : k)) $display("FAIL sat_count%0d: got %0d, required %0d", k, s_op_count, (k > 3) ? 3 : k);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_tie();
    test_saturation();
    n_total++;
    if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
    n_pass  += mon_pass;
    n_total += mon_total;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
